// File: rtl/extend_shift_unit_if.sv
// extend_shift_unit_if: operand, control and result bundle for the extend/shift stage.
// Zero is present only when ESU_ZERO_FLAG_EN is defined.
interface extend_shift_unit_if #(parameter int WIDTH = 16);
    logic [3:0]       IR3_0;
    logic [7:0]       IR7_0;
    logic [WIDTH-1:0] Reg_A;
    logic [WIDTH-1:0] ALUOut;
    logic [1:0]       ShifterInput;
    logic             ShifterLeft;
    logic [1:0]       ShiftAmount;
    logic [WIDTH-1:0] O;
`ifdef ESU_ZERO_FLAG_EN
    logic             Zero;
    modport master (output IR3_0, IR7_0, Reg_A, ALUOut, ShifterInput, ShifterLeft, ShiftAmount, input O, Zero);
    modport slave  (input IR3_0, IR7_0, Reg_A, ALUOut, ShifterInput, ShifterLeft, ShiftAmount, output O, Zero);
`else
    modport master (output IR3_0, IR7_0, Reg_A, ALUOut, ShifterInput, ShifterLeft, ShiftAmount, input O);
    modport slave  (input IR3_0, IR7_0, Reg_A, ALUOut, ShifterInput, ShifterLeft, ShiftAmount, output O);
`endif
endinterface

// File: rtl/extend_shift_unit.sv
// extend_shift_unit: sign-extend one of four sources, shift left/arith-right, register result.
// Optional registered Zero flag when ESU_ZERO_FLAG_EN is defined.
module extend_shift_unit #(parameter int WIDTH = 16) (
    input logic CLK,
    input logic Reset,
    extend_shift_unit_if.slave bus
);
    logic [WIDTH-1:0]        ext;
    logic [WIDTH-1:0]        shl;
    logic signed [WIDTH-1:0] sra;
    logic [WIDTH-1:0]        sh;
    logic [3:0]              amt;
    always_comb begin
        ext = bus.ShifterInput == 2'b00 ? {{(WIDTH-4){bus.IR3_0[3]}}, bus.IR3_0} :
              bus.ShifterInput == 2'b01 ? {{(WIDTH-8){bus.IR7_0[7]}}, bus.IR7_0} :
              bus.ShifterInput == 2'b10 ? bus.Reg_A : bus.ALUOut;
        amt = bus.ShiftAmount == 2'b00 ? 4'd1 :
              bus.ShiftAmount == 2'b01 ? bus.IR3_0 :
              bus.ShiftAmount == 2'b10 ? 4'd0 : 4'd4;
        shl = ext << amt;
        // kept in its own signed variable so the ternary below cannot demote it to a logical shift
        sra = $signed(ext) >>> amt;
        sh  = bus.ShifterLeft ? shl : sra;
    end
    always_ff @(posedge CLK) begin
        bus.O <= Reset ? '0 : sh;
`ifdef ESU_ZERO_FLAG_EN
        bus.Zero <= Reset ? 1'b1 : (sh == '0);
`endif
    end
endmodule

// File: tb/tb_extend_shift_unit.sv
// tb_extend_shift_unit: directed vector table, reset sequences and randomized checks vs an arithmetic model.
module tb_extend_shift_unit;
    logic clk = 0;
    logic rst = 1;
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    extend_shift_unit_if #(.WIDTH(16)) bus ();
    extend_shift_unit #(.WIDTH(16)) dut (.CLK(clk), .Reset(rst), .bus(bus));
    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  ir3;
        logic [7:0]  ir7;
        logic [15:0] ra;
        logic [15:0] ao;
        logic        left;
        logic [1:0]  amt;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [13];
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic chk_out(input string name, input logic [15:0] exp);
        chk(name, bus.O, exp);
`ifdef ESU_ZERO_FLAG_EN
        chk({name, "_zero"}, {15'd0, bus.Zero}, {15'd0, exp == 16'h0});
`endif
    endtask
    task automatic drive(input vec_t v);
        bus.ShifterInput = v.sel;
        bus.IR3_0 = v.ir3;
        bus.IR7_0 = v.ir7;
        bus.Reg_A = v.ra;
        bus.ALUOut = v.ao;
        bus.ShifterLeft = v.left;
        bus.ShiftAmount = v.amt;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic int sx(input int val, input int bits);
        return val >= (1 << (bits - 1)) ? val - (1 << bits) : val;
    endfunction
    function automatic logic [15:0] model(input vec_t v);
        int val, n, d, q;
        val = v.sel == 2'd0 ? sx(int'(v.ir3), 4) :
              v.sel == 2'd1 ? sx(int'(v.ir7), 8) :
              v.sel == 2'd2 ? sx(int'(v.ra), 16) : sx(int'(v.ao), 16);
        n = v.amt == 2'd0 ? 1 : v.amt == 2'd1 ? int'(v.ir3) : v.amt == 2'd2 ? 0 : 4;
        d = 1 << n;
        if (v.left) q = val * d;
        else begin
            q = val / d;
            if (val < 0 && (val % d) != 0) q = q - 1;
        end
        return 16'(q & 32'hFFFF);
    endfunction
    initial begin
        vec_t v;
        logic [15:0] e;
        vecs[0]  = '{2'b01, 4'h1, 8'h81, 16'h0000, 16'h0000, 1'b0, 2'b01, 16'hFFC0};
        vecs[1]  = '{2'b01, 4'h1, 8'h81, 16'h0000, 16'h0000, 1'b1, 2'b01, 16'hFF02};
        vecs[2]  = '{2'b01, 4'h1, 8'h81, 16'h0000, 16'h0000, 1'b1, 2'b11, 16'hF810};
        vecs[3]  = '{2'b01, 4'h1, 8'h81, 16'h0000, 16'h0000, 1'b1, 2'b10, 16'hFF81};
        vecs[4]  = '{2'b01, 4'h1, 8'h81, 16'h0000, 16'h0000, 1'b1, 2'b00, 16'hFF02};
        vecs[5]  = '{2'b00, 4'h1, 8'h00, 16'h0000, 16'h0000, 1'b1, 2'b00, 16'h0002};
        vecs[6]  = '{2'b00, 4'h8, 8'h00, 16'h0000, 16'h0000, 1'b1, 2'b10, 16'hFFF8};
        vecs[7]  = '{2'b10, 4'h0, 8'h00, 16'h1111, 16'h0000, 1'b1, 2'b00, 16'h2222};
        vecs[8]  = '{2'b11, 4'h0, 8'h00, 16'h0000, 16'h0F0F, 1'b1, 2'b00, 16'h1E1E};
        vecs[9]  = '{2'b10, 4'hF, 8'h00, 16'h8000, 16'h0000, 1'b0, 2'b01, 16'hFFFF};
        vecs[10] = '{2'b10, 4'hF, 8'h00, 16'h8000, 16'h0000, 1'b1, 2'b01, 16'h0000};
        vecs[11] = '{2'b11, 4'h5, 8'h3C, 16'hABCD, 16'h7FFF, 1'b0, 2'b11, 16'h07FF};
        vecs[12] = '{2'b10, 4'h0, 8'hFF, 16'h8001, 16'h1234, 1'b0, 2'b01, 16'h8001};
        drive(vecs[0]);
        tick();
        chk_out("reset_state", 16'h0000);
        rst = 0;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].exp);
        end
        drive(vecs[7]);
        rst = 1;
        tick();
        chk_out("mid_reset", 16'h0000);
        rst = 0;
        tick();
        chk_out("after_reset", 16'h2222);
        rst = 1;
        tick();
        drive(vecs[0]);
        rst = 0;
        tick();
        chk_out("reset_then_new", 16'hFFC0);
        for (int i = 0; i < 400; i++) begin
            v.sel  = 2'($urandom);
            v.ir3  = 4'($urandom);
            v.ir7  = 8'($urandom);
            v.ra   = 16'($urandom);
            v.ao   = 16'($urandom);
            v.left = 1'($urandom);
            v.amt  = 2'($urandom);
            drive(v);
            rst = ($urandom_range(0, 19) == 0);
            e = rst ? 16'h0000 : model(v);
            tick();
            chk_out($sformatf("rand%0d", i), e);
        end
        rst = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
